// File: rtl/axi_stream_slave.sv
// axi_stream_slave: burst-bus responder in front of a small register memory.
// One address handshake starts a burst; BURST_LEN read beats stream out or
// BURST_LEN write beats stream in, the latter closed by a single OKAY response.
// A combinational debug port exposes any memory entry at any time.
module axi_stream_slave #(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 4,
   parameter int BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ar_valid,
   input  logic [ADDR_W-1:0] ar_addr,
   output logic              ar_ready,
   output logic              r_valid,
   output logic [DATA_W-1:0] r_data,
   output logic              r_last,
   input  logic              r_ready,
   input  logic              aw_valid,
   input  logic [ADDR_W-1:0] aw_addr,
   output logic              aw_ready,
   input  logic              w_valid,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_ready,
   output logic              b_valid,
   output logic [1:0]        b_resp,
   input  logic              b_ready,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_DATA = 2'd1;
   localparam logic [1:0] WR_DATA = 2'd2;
   localparam logic [1:0] WR_RESP = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;

   // Output decode: every handshake signal is a pure function of the state,
   // except aw_ready which yields to a concurrent read request in IDLE.
   always_comb begin
      ar_ready = (state_q == IDLE);
      aw_ready = (state_q == IDLE) && !ar_valid;
      r_valid  = (state_q == RD_DATA);
      r_last   = (state_q == RD_DATA) && (cnt_q == LAST_CNT);
      w_ready  = (state_q == WR_DATA);
      b_valid  = (state_q == WR_RESP);
      b_resp   = 2'b00;
      busy     = (state_q != IDLE);
      r_data   = mem_q[ptr_q];
      dbg_data = mem_q[dbg_addr];
   end

   // Next-state logic: burst sequencing, pointer wrap and beat counting.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ar_valid) begin
               ptr_d   = ar_addr;
               cnt_d   = '0;
               state_d = RD_DATA;
            end else if (aw_valid) begin
               ptr_d   = aw_addr;
               cnt_d   = '0;
               state_d = WR_DATA;
            end
         end
         RD_DATA: begin
            if (r_ready) begin
               ptr_d = ptr_q + ADDR_W'(1);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) state_d = IDLE;
            end
         end
         WR_DATA: begin
            if (w_valid) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + ADDR_W'(1);
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (b_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers; reset aborts any burst without a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Register memory; cleared by reset so partial write bursts leave no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[ptr_q] <= w_data;
      end
   end

endmodule

// File: tb/tb_axi_stream_slave.sv
// Directed + randomized bench for axi_stream_slave against a memory-array model.
`timescale 1ns/1ps
module tb_axi_stream_slave;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 4;
   localparam int BL     = 8;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              ar_valid, ar_ready, r_valid, r_last, r_ready;
   logic [ADDR_W-1:0] ar_addr, aw_addr, dbg_addr;
   logic [DATA_W-1:0] r_data, w_data, dbg_data;
   logic              aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, busy;
   logic [1:0]        b_resp;

   logic [DATA_W-1:0] mem_m [DEPTH];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_stream_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
      .r_valid(r_valid), .r_data(r_data), .r_last(r_last), .r_ready(r_ready),
      .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare every memory entry through the debug port (only while idle).
   task automatic check_mem(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         dbg_addr = ADDR_W'(a);
         #1;
         check(tag, {28'd0, dbg_data}, {28'd0, mem_m[a]});
      end
   endtask

   // mode 0: data 2i+1, w_valid held; 1: data 2i, held; 2: random data and gaps.
   task automatic write_burst(input int addr, input int mode);
      int i, stalls;
      logic wv;
      logic [DATA_W-1:0] d;
      aw_valid = 1'b1;
      aw_addr  = ADDR_W'(addr);
      #1;
      check("wr_aw_ready", {31'd0, aw_ready}, 1);
      step();
      aw_valid = 1'b0;
      i = 0; stalls = 0;
      while (i < BL) begin
         check("wr_w_ready", {31'd0, w_ready}, 1);
         check("wr_b_valid_early", {31'd0, b_valid}, 0);
         check("wr_busy", {31'd0, busy}, 1);
         wv = 1'b1;
         if (mode == 2 && stalls < 3 && $urandom_range(0, 3) == 0) wv = 1'b0;
         d = (mode == 0) ? DATA_W'(2 * i + 1) : (mode == 1) ? DATA_W'(2 * i) : DATA_W'($urandom);
         w_valid = wv;
         w_data  = d;
         step();
         if (wv) begin
            mem_m[(addr + i) % DEPTH] = d;
            i++;
            stalls = 0;
         end else begin
            stalls++;
         end
      end
      w_valid = 1'b0;
      check("wr_b_valid", {31'd0, b_valid}, 1);
      check("wr_b_resp", {30'd0, b_resp}, 0);
      check("wr_w_ready_resp", {31'd0, w_ready}, 0);
      if (mode == 2) begin
         step();
         check("wr_b_hold", {31'd0, b_valid}, 1);
      end
      b_ready = 1'b1;
      step();
      b_ready = 1'b0;
      check("wr_b_fall", {31'd0, b_valid}, 0);
      check("wr_idle_busy", {31'd0, busy}, 0);
      check("wr_idle_ar_ready", {31'd0, ar_ready}, 1);
   endtask

   // Read beats only (address already accepted). mode 0: r_ready=1;
   // 1: r_ready toggles 1,0,1,0; 2: random r_ready.
   task automatic read_beats(input int addr, input int mode);
      int i, k, stalls;
      logic rr;
      i = 0; k = 0; stalls = 0;
      while (i < BL) begin
         check("rd_r_valid", {31'd0, r_valid}, 1);
         check("rd_r_data", {28'd0, r_data}, {28'd0, mem_m[(addr + i) % DEPTH]});
         check("rd_r_last", {31'd0, r_last}, (i == BL - 1) ? 1 : 0);
         check("rd_ar_ready", {31'd0, ar_ready}, 0);
         check("rd_aw_ready", {31'd0, aw_ready}, 0);
         rr = 1'b1;
         if (mode == 1) rr = (k % 2 == 0);
         if (mode == 2 && stalls < 3 && $urandom_range(0, 2) == 0) rr = 1'b0;
         r_ready = rr;
         step();
         k++;
         if (rr) begin i++; stalls = 0; end else stalls++;
      end
      r_ready = 1'b0;
      check("rd_done_r_valid", {31'd0, r_valid}, 0);
      check("rd_done_busy", {31'd0, busy}, 0);
      check("rd_done_ar_ready", {31'd0, ar_ready}, 1);
   endtask

   task automatic read_burst(input int addr, input int mode);
      ar_valid = 1'b1;
      ar_addr  = ADDR_W'(addr);
      #1;
      check("rd_ar_ready_idle", {31'd0, ar_ready}, 1);
      step();
      ar_valid = 1'b0;
      read_beats(addr, mode);
   endtask

   initial begin
      int wa, ra;
      rst = 1'b1;
      ar_valid = 0; ar_addr = 0; r_ready = 0;
      aw_valid = 0; aw_addr = 0; w_valid = 0; w_data = 0; b_ready = 0; dbg_addr = 0;
      for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      #12;
      // Reset state
      check("rst_ar_ready", {31'd0, ar_ready}, 1);
      check("rst_aw_ready", {31'd0, aw_ready}, 1);
      check("rst_r_valid", {31'd0, r_valid}, 0);
      check("rst_r_last", {31'd0, r_last}, 0);
      check("rst_w_ready", {31'd0, w_ready}, 0);
      check("rst_b_valid", {31'd0, b_valid}, 0);
      check("rst_b_resp", {30'd0, b_resp}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check_mem("rst_mem");
      rst = 1'b0;
      step();

      // Directed write/read at 0, then wrap with backpressure at 5
      write_burst(0, 0);
      check_mem("mem_after_wr0");
      read_burst(0, 0);
      write_burst(5, 1);
      check_mem("mem_after_wr5");
      read_burst(5, 1);

      // Simultaneous requests: read first, pending write taken on return to IDLE
      wa = 3; ra = 6;
      ar_valid = 1'b1; ar_addr = ADDR_W'(ra);
      aw_valid = 1'b1; aw_addr = ADDR_W'(wa);
      #1;
      check("sim_aw_ready", {31'd0, aw_ready}, 0);
      check("sim_ar_ready", {31'd0, ar_ready}, 1);
      step();
      ar_valid = 1'b0;
      read_beats(ra, 0);
      check("sim_aw_ready_after", {31'd0, aw_ready}, 1);
      write_burst(wa, 2);
      check_mem("mem_after_sim");

      // Randomized bursts against the model
      for (int n = 0; n < 6; n++) begin
         wa = $urandom_range(0, DEPTH - 1);
         ra = $urandom_range(0, DEPTH - 1);
         write_burst(wa, 2);
         read_burst(ra, 2);
      end
      check_mem("mem_after_rand");

      // Reset after 3 of 8 write beats
      aw_valid = 1'b1; aw_addr = 3'd2;
      step();
      aw_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         w_valid = 1'b1; w_data = DATA_W'(b + 9);
         step();
      end
      #3;
      rst = 1'b1;
      #1;
      check("mrst_busy", {31'd0, busy}, 0);
      check("mrst_w_ready", {31'd0, w_ready}, 0);
      check("mrst_b_valid", {31'd0, b_valid}, 0);
      check("mrst_ar_ready", {31'd0, ar_ready}, 1);
      for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      w_valid = 1'b0;
      #2;
      rst = 1'b0;
      check_mem("mrst_mem");
      w_valid = 1'b1; w_data = 4'hF;
      for (int c = 0; c < 4; c++) begin
         step();
         check("mrst_no_b_valid", {31'd0, b_valid}, 0);
         check("mrst_idle", {31'd0, busy}, 0);
      end
      w_valid = 1'b0;
      check_mem("mrst_mem_ignored_w");
      read_burst(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_stream_slave.md
Name: axi_stream_slave

Overview:
- Responder end of the 3-bit-address / 4-bit-data burst bus driven by the board's bus master.
- Holds an 8-entry x 4-bit register memory.
- Accepts one address handshake per burst, then streams BURST_LEN read beats out or accepts BURST_LEN write beats in, followed by a single write response.
- Sits between the master and the on-board storage; a debug read port lets LEDs or the testbench inspect memory contents.

Parameters:
ADDR_W, 3, address width; memory depth = 2**ADDR_W
DATA_W, 4, data width per beat
BURST_LEN, 8, beats per read or write burst (1..2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
ar_valid  input  1  read address valid
ar_addr  input  ADDR_W  read burst start address
ar_ready  output  1  read address accepted
r_valid  output  1  read data valid
r_data  output  DATA_W  read data beat
r_last  output  1  final read beat of burst
r_ready  input  1  master accepts read beat
aw_valid  input  1  write address valid
aw_addr  input  ADDR_W  write burst start address
aw_ready  output  1  write address accepted
w_valid  input  1  write data valid
w_data  input  DATA_W  write data beat
w_ready  output  1  slave accepts write beat
b_valid  output  1  write response valid
b_resp  output  2  response code, always 2'b00 (OKAY)
b_ready  input  1  master accepts response
dbg_addr  input  ADDR_W  debug memory index
dbg_data  output  DATA_W  mem[dbg_addr], combinational
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (clk = clk, rst = rst, asynchronous, active-high):
  - state = IDLE; all memory entries = 0; beat counter and pointer = 0.
  - Outputs: ar_ready = 1 (IDLE decode), aw_ready = !ar_valid, r_valid = 0, r_last = 0, w_ready = 0, b_valid = 0, b_resp = 0, busy = 0.
- Handshake rule: a transfer occurs on a rising edge where valid && ready are both high. Valid and ready are independent; neither waits on the other.
- States: IDLE, RD_DATA, WR_DATA, WR_RESP. Encoding is registered; outputs are decoded from state.
- IDLE:
  - ar_ready = 1; aw_ready = ~ar_valid.
  - If ar_valid: ptr <= ar_addr, cnt <= 0, go to RD_DATA.
  - Else if aw_valid: ptr <= aw_addr, cnt <= 0, go to WR_DATA.
  - Read wins a simultaneous request. The write address is not consumed and stays pending.
- RD_DATA:
  - r_valid = 1; r_data = mem[ptr] (combinational from the register array); r_last = (cnt == BURST_LEN-1).
  - On r_ready: ptr <= ptr+1 (wraps mod 2**ADDR_W), cnt <= cnt+1.
  - After the last beat transfers, go to IDLE.
  - Without r_ready, r_data and r_last hold stable.
- WR_DATA:
  - w_ready = 1.
  - On w_valid: mem[ptr] <= w_data, ptr <= ptr+1 (wraps), cnt <= cnt+1.
  - After beat BURST_LEN transfers, go to WR_RESP.
  - w_valid with w_ready low (any other state) is ignored.
- WR_RESP:
  - b_valid = 1, b_resp = 2'b00.
  - On b_ready, go to IDLE; b_valid falls the next cycle.
- Latency:
  - Address handshake at edge N → first r_valid or w_ready high in the cycle after N.
  - Minimum read burst = BURST_LEN cycles plus 1 address cycle.
  - Minimum write = BURST_LEN + 2 cycles.
- Widths: cnt is $clog2(BURST_LEN+1) bits; ptr is ADDR_W bits with natural wrap 7→0.
- ar_valid or aw_valid asserted outside IDLE is ignored (ready low); it is serviced on return to IDLE.
- Reset mid-burst: immediate return to IDLE. Memory is cleared; partial write data is lost. No b_valid is issued.
- busy = (state != IDLE).

Test Plan:
- Reset: assert rst mid-cycle → within the same cycle r_valid=0, w_ready=0, b_valid=0, ar_ready=1; dbg_data=0 for all dbg_addr 0..7.
- Write burst: aw_addr=0; w_data 1,3,5,...,15 with w_valid held high → mem[0..7]=1,3,...,15; b_valid high in the cycle after the 8th beat with b_resp=00; b_ready=1 → IDLE.
- Read burst: after the write above, ar_addr=0, r_ready=1 → r_data sequence 1,3,5,...,15 on 8 consecutive cycles; r_last high only on the beat with value 15; ar_ready high again afterwards.
- Wrap and backpressure:
  - Write with aw_addr=5, data 0,2,...,14 → mem[5]=0, mem[6]=2, mem[7]=4, mem[0]=6, ..., mem[4]=14.
  - Read from addr 5 with r_ready toggling 1,0,1,0 → each beat held while r_ready=0; returned order 0,2,...,14.
- Simultaneous requests: ar_valid=aw_valid=1 in IDLE → aw_ready=0, read burst runs first; the write address is accepted on the first IDLE cycle after the read completes.
- Reset mid-write: assert rst after 3 of 8 write beats → state IDLE, busy=0, all mem = 0, b_valid never asserted.
